// File: rtl/lvds_word_align.sv
// LVDS deserializer word aligner: bit-slips until ALIGN_PATTERN is seen.
// Define WA_RELOCK_EN to retrain from DONE when rx_locked drops.
module lvds_word_align #(
  parameter logic [7:0] ALIGN_PATTERN = 8'hBC,
  parameter int MATCH_COUNT = 16,
  parameter int LOCK_DELAY  = 64,
  parameter int SLIP_WAIT   = 8,
  parameter int MAX_SLIPS   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_locked,
  input  logic [7:0] rx_out,
  output logic       rx_data_align,
  output logic       align_done,
  output logic       align_err,
  output logic [3:0] slip_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOCK_WAIT = 3'd1,
    CHECK     = 3'd2,
    SLIP      = 3'd3,
    SETTLE    = 3'd4,
    DONE      = 3'd5
  } st_t;

  localparam int DW = (LOCK_DELAY  > 1) ? $clog2(LOCK_DELAY)  : 1;
  localparam int MW = (MATCH_COUNT > 1) ? $clog2(MATCH_COUNT) : 1;
  localparam int SW = (SLIP_WAIT   > 1) ? $clog2(SLIP_WAIT)   : 1;

  st_t st, st_n;
  logic [DW-1:0] dly, dly_n;
  logic [MW-1:0] mcnt, mcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic          phase, phase_n;
  logic [3:0]    slip_n;
  logic          err_n;

  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      dly           <= '0;
      mcnt          <= '0;
      scnt          <= '0;
      phase         <= 1'b0;
      slip_cnt      <= '0;
      align_err     <= 1'b0;
      rx_data_align <= 1'b0;
      align_done    <= 1'b0;
    end else begin
      st            <= st_n;
      dly           <= dly_n;
      mcnt          <= mcnt_n;
      scnt          <= scnt_n;
      phase         <= phase_n;
      slip_cnt      <= slip_n;
      align_err     <= err_n;
      rx_data_align <= (st_n == SLIP);
      align_done    <= (st_n == DONE);
    end
  end

  always_comb begin
    st_n    = st;
    dly_n   = dly;
    mcnt_n  = mcnt;
    scnt_n  = scnt;
    phase_n = phase;
    slip_n  = slip_cnt;
    err_n   = align_err;
    unique case (st)
      IDLE: begin
        if (rx_locked) begin
          st_n  = LOCK_WAIT;
          dly_n = '0;
        end
      end
      LOCK_WAIT: begin
        if (!rx_locked) begin
          st_n = IDLE;
        end else if (dly == DW'(LOCK_DELAY - 1)) begin
          st_n   = CHECK;
          slip_n = '0;
          mcnt_n = '0;
        end else begin
          dly_n = dly + 1'b1;
        end
      end
      CHECK: begin
        if (!rx_locked) begin
          st_n   = IDLE;
          mcnt_n = '0;
        end else if (rx_out == ALIGN_PATTERN) begin
          if (mcnt == MW'(MATCH_COUNT - 1)) begin
            st_n  = DONE;
            err_n = 1'b0;
          end else begin
            mcnt_n = mcnt + 1'b1;
          end
        end else begin
          st_n    = SLIP;
          mcnt_n  = '0;
          phase_n = 1'b0;
          // a full rotation without a match means the link is bad
          if (slip_cnt == 4'(MAX_SLIPS - 1)) begin
            slip_n = '0;
            err_n  = 1'b1;
          end else begin
            slip_n = slip_cnt + 1'b1;
          end
        end
      end
      SLIP: begin
        if (!rx_locked) begin
          st_n   = IDLE;
          mcnt_n = '0;
        end else if (phase) begin
          st_n   = SETTLE;
          scnt_n = '0;
        end else begin
          phase_n = 1'b1;
        end
      end
      SETTLE: begin
        if (!rx_locked) begin
          st_n   = IDLE;
          mcnt_n = '0;
        end else if (scnt == SW'(SLIP_WAIT - 1)) begin
          st_n   = CHECK;
          mcnt_n = '0;
        end else begin
          scnt_n = scnt + 1'b1;
        end
      end
      DONE: begin
`ifdef WA_RELOCK_EN
        if (!rx_locked) begin
          st_n   = IDLE;
          mcnt_n = '0;
        end
`else
        st_n = DONE;
`endif
      end
      default: st_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lvds_word_align.sv
// Bench for lvds_word_align: rotating deserializer model, vector table
// with scoreboard, plus hand sequences for drop, reset and relock cases.
module tb_lvds_word_align;

  localparam logic [7:0] PAT = 8'hBC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_locked = 1'b0;
  logic [7:0] rx_out = 8'h00;
  logic       rx_data_align;
  logic       align_done;
  logic       align_err;
  logic [3:0] slip_cnt;
  logic [2:0] state;

  lvds_word_align dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_locked    (rx_locked),
    .rx_out       (rx_out),
    .rx_data_align(rx_data_align),
    .align_done   (align_done),
    .align_err    (align_err),
    .slip_cnt     (slip_cnt),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rot;
    bit zero;
    int stop;
    int done;
    int sc;
    int err;
    int pulses;
    int checks;
  } vec_t;

  int nvec = 0;
  int nbad = 0;
  int rot, pulses, hi, lo, lw_cnt, ck_cnt, bad_slip;
  bit zero;
  vec_t exp_q[$];
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotr(input int r);
    logic [15:0] d;
    d = {PAT, PAT};
    d = d >> r;
    return d[7:0];
  endfunction

  task automatic clr_mon();
    pulses = 0; hi = 0; lo = 0;
    lw_cnt = 0; ck_cnt = 0; bad_slip = 0;
  endtask

  task automatic step();
    rx_out = zero ? 8'h00 : rotr(rot);
    @(posedge clk);
    #1;
    if (state == 3'd1) lw_cnt++;
    if (state == 3'd2) ck_cnt++;
    if (rx_data_align && state != 3'd3) bad_slip++;
    if (rx_data_align) begin
      if (hi == 0) begin
        pulses++;
        rot = (rot + 7) % 8;
        if (pulses > 1) chk("slip_gap", lo, 9);
      end
      hi++;
      lo = 0;
    end else begin
      if (hi != 0) chk("pulse_width", hi, 2);
      hi = 0;
      lo++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_locked = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr_mon();
  endtask

  task automatic run_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      if (align_done) ok = 1'b1;
    end
  endtask

  initial begin
    vec_t v, e;
    bit ok;
    tbl[0] = '{0, 0, 0, 1, 0, 0, 0, 16};
    tbl[1] = '{3, 0, 0, 1, 3, 0, 3, 19};
    tbl[2] = '{1, 0, 0, 1, 1, 0, 1, 17};
    tbl[3] = '{7, 0, 0, 1, 7, 0, 7, 23};
    tbl[4] = '{0, 1, 7, 0, 7, 0, 7, 7};
    tbl[5] = '{0, 1, 8, 0, 0, 1, 8, 8};
    tbl[6] = '{0, 1, 10, 0, 2, 1, 10, 10};
    zero = 1'b0;
    rot = 0;
    clr_mon();

    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_align", int'(rx_data_align), 0);
    chk("rst_done", int'(align_done), 0);
    chk("rst_err", int'(align_err), 0);
    chk("rst_slip", int'(slip_cnt), 0);

    for (int i = 0; i < 7; i++) begin
      v = tbl[i];
      exp_q.push_back(v);
      do_reset();
      rot = v.rot;
      zero = v.zero;
      rx_locked = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
        step();
        if (align_done) ok = 1'b1;
        if (v.stop != 0 && pulses >= v.stop) ok = 1'b1;
      end
      e = exp_q.pop_front();
      chk($sformatf("v%0d_finish", i), int'(ok), 1);
      chk($sformatf("v%0d_done", i), int'(align_done), e.done);
      chk($sformatf("v%0d_slip_cnt", i), int'(slip_cnt), e.sc);
      chk($sformatf("v%0d_err", i), int'(align_err), e.err);
      chk($sformatf("v%0d_pulses", i), pulses, e.pulses);
      chk($sformatf("v%0d_checks", i), ck_cnt, e.checks);
      chk($sformatf("v%0d_lockwait", i), lw_cnt, 64);
      chk($sformatf("v%0d_slip_state", i), bad_slip, 0);
    end

    // rx_locked dropped in the second cycle of a slip pulse
    do_reset();
    rot = 3;
    zero = 1'b0;
    rx_locked = 1'b1;
    for (int c = 0; c < 200 && hi == 0; c++) step();
    chk("drop_first_hi", hi, 1);
    step();
    chk("drop_second_state", int'(state), 3);
    rx_locked = 1'b0;
    step();
    chk("drop_align", int'(rx_data_align), 0);
    chk("drop_state", int'(state), 0);
    chk("drop_done", int'(align_done), 0);
    chk("drop_slip_hold", int'(slip_cnt), 1);

    // align_err clears on entry to DONE
    do_reset();
    zero = 1'b1;
    rx_locked = 1'b1;
    for (int c = 0; c < 300 && pulses < 8; c++) step();
    chk("err_set", int'(align_err), 1);
    zero = 1'b0;
    rot = 0;
    run_done(100, ok);
    chk("err_recover_done", int'(ok), 1);
    chk("err_cleared", int'(align_err), 0);

    // asynchronous reset in SETTLE, then full retrain
    do_reset();
    rot = 1;
    zero = 1'b0;
    rx_locked = 1'b1;
    for (int c = 0; c < 200 && state != 3'd4; c++) step();
    chk("ar_in_settle", int'(state), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_state", int'(state), 0);
    chk("ar_slip", int'(slip_cnt), 0);
    chk("ar_done", int'(align_done), 0);
    chk("ar_err", int'(align_err), 0);
    chk("ar_align", int'(rx_data_align), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_mon();
    run_done(200, ok);
    chk("ar_retrain", int'(ok), 1);
    chk("ar_lockwait", lw_cnt, 64);
    chk("ar_slip_after", int'(slip_cnt), 0);

    // rx_locked glitch while in DONE
    rx_locked = 1'b0;
    step();
    rx_locked = 1'b1;
`ifdef WA_RELOCK_EN
    chk("relock_done_low", int'(align_done), 0);
    chk("relock_state", int'(state), 0);
    clr_mon();
    run_done(200, ok);
    chk("relock_retrain", int'(ok), 1);
    chk("relock_lockwait", lw_cnt, 64);
`else
    chk("relock_done_hold", int'(align_done), 1);
    repeat (5) step();
    chk("relock_done_stay", int'(align_done), 1);
    chk("relock_state", int'(state), 5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
